mul_64x64_pipe: RTL

- Pipelined 64x64 -> 128-bit unsigned multiplier for the NTT datapath.
- Sits directly upstream of the Goldilocks modular reduction stage (prime 2^64 - 2^32 + 1). Its 128-bit product feeds that stage's DATA_IN.
- Carries a valid bit and a user tag alongside the data, so the butterfly controller can realign results with their addresses.
- Global stall input (EN) freezes the whole pipeline.

---
 rtl/mul_64x64_pipe.sv | 99 +++++++++
 1 files changed

// File: rtl/mul_64x64_pipe.sv
// Three-stage pipelined 64x64 -> 128-bit unsigned multiplier with valid and tag sideband.
// EN freezes every register; RST asynchronously empties the pipeline.
module mul_64x64_pipe #(
   parameter int TAG_W   = 8,
   parameter int LATENCY = 3
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               EN,
   input  logic               IN_VALID,
   input  logic [63:0]        A,
   input  logic [63:0]        B,
   input  logic [TAG_W-1:0]   IN_TAG,
   output logic               OUT_VALID,
   output logic [127:0]       DATA_OUT,
   output logic [TAG_W-1:0]   OUT_TAG
);

   logic [LATENCY-1:0] vld_q, vld_d;

   logic [63:0]        s1_a_q, s1_a_d;
   logic [63:0]        s1_b_q, s1_b_d;
   logic [TAG_W-1:0]   s1_tag_q, s1_tag_d;

   logic [63:0]        pp_ll_q, pp_ll_d;
   logic [63:0]        pp_lh_q, pp_lh_d;
   logic [63:0]        pp_hl_q, pp_hl_d;
   logic [63:0]        pp_hh_q, pp_hh_d;
   logic [TAG_W-1:0]   s2_tag_q, s2_tag_d;

   logic [127:0]       out_data_q, out_data_d;
   logic [TAG_W-1:0]   out_tag_q, out_tag_d;

   logic [64:0]        mid;

   // Data registers load on every enabled edge, bubbles included, so idle output stays deterministic.
   always_comb begin
      vld_d      = vld_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      s1_tag_d   = s1_tag_q;
      pp_ll_d    = pp_ll_q;
      pp_lh_d    = pp_lh_q;
      pp_hl_d    = pp_hl_q;
      pp_hh_d    = pp_hh_q;
      s2_tag_d   = s2_tag_q;
      out_data_d = out_data_q;
      out_tag_d  = out_tag_q;
      mid        = {1'b0, pp_lh_q} + {1'b0, pp_hl_q};

      if (EN) begin
         vld_d      = {vld_q[LATENCY-2:0], IN_VALID};
         s1_a_d     = A;
         s1_b_d     = B;
         s1_tag_d   = IN_TAG;
         pp_ll_d    = 64'(s1_a_q[31:0])  * 64'(s1_b_q[31:0]);
         pp_lh_d    = 64'(s1_a_q[31:0])  * 64'(s1_b_q[63:32]);
         pp_hl_d    = 64'(s1_a_q[63:32]) * 64'(s1_b_q[31:0]);
         pp_hh_d    = 64'(s1_a_q[63:32]) * 64'(s1_b_q[63:32]);
         s2_tag_d   = s1_tag_q;
         // The 65-bit mid sum keeps its carry, which lands on bit 96 of the product.
         out_data_d = {pp_hh_q, 64'd0} + {31'd0, mid, 32'd0} + {64'd0, pp_ll_q};
         out_tag_d  = s2_tag_q;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         vld_q      <= '0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s1_tag_q   <= '0;
         pp_ll_q    <= '0;
         pp_lh_q    <= '0;
         pp_hl_q    <= '0;
         pp_hh_q    <= '0;
         s2_tag_q   <= '0;
         out_data_q <= '0;
         out_tag_q  <= '0;
      end else begin
         vld_q      <= vld_d;
         s1_a_q     <= s1_a_d;
         s1_b_q     <= s1_b_d;
         s1_tag_q   <= s1_tag_d;
         pp_ll_q    <= pp_ll_d;
         pp_lh_q    <= pp_lh_d;
         pp_hl_q    <= pp_hl_d;
         pp_hh_q    <= pp_hh_d;
         s2_tag_q   <= s2_tag_d;
         out_data_q <= out_data_d;
         out_tag_q  <= out_tag_d;
      end
   end

   assign OUT_VALID = vld_q[LATENCY-1];
   assign DATA_OUT  = out_data_q;
   assign OUT_TAG   = out_tag_q;

endmodule
